// File: rtl/sd_stream_ctrl.sv
// Purpose: feeds a parallel word LSB-first into a serial sequence detector and tallies its matches.
// Latency: done pulses WIDTH+DET_LAT+1 edges after the accepting edge (clear, shift, drain).
// Backpressure: in_ready is low for the whole scan; held words wait, none are dropped.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     word handshake, in_data bit 0 is shifted out first
//   abort                 cancels a scan in progress (clear/shift/drain), results zeroed
//   sd_rst, sd_i, sd_o    detector clear pulse, serial bit out, detector output in
//   done                  one-cycle pulse when match_cnt/first_idx/found are final
//   match_cnt, first_idx  number of attributed matches, bit index of the first one
//   found                 at least one match seen in the last scan
module sd_stream_ctrl #(
  parameter int WIDTH   = 10,
  parameter int DET_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         abort,
  output logic                         sd_rst,
  output logic                         sd_i,
  input  logic                         sd_o,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   match_cnt,
  output logic [$clog2(WIDTH+1)-1:0]   first_idx,
  output logic                         found
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int SCAN_LEN = WIDTH + DET_LAT;
  // Counter spans the shift cycles plus the drain cycles.
  localparam int CYC_W    = $clog2(SCAN_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CYC_W-1:0] cyc;
  logic             samp;
  logic [CYC_W-1:0] k_idx;
  logic             scanning;

  assign in_ready = (state == S_IDLE) && !rst;
  assign sd_rst   = rst || (state == S_CLR);
  assign sd_i     = (state == S_SHIFT) && shreg[0];
  assign done     = (state == S_DONE);
  assign scanning = (state == S_CLR) || (state == S_SHIFT) || (state == S_DRAIN);

  // sd_o seen at the end of scan cycle cyc belongs to bit cyc-DET_LAT.
  assign k_idx = cyc - CYC_W'(DET_LAT);

  // With a combinational detector every shift cycle samples its own bit; otherwise
  // the first DET_LAT shift cycles still show the cleared detector and are skipped.
  generate
    if (DET_LAT == 0) begin : g_comb_det
      assign samp = (state == S_SHIFT);
    end else begin : g_lat_det
      assign samp = ((state == S_SHIFT) && (cyc >= CYC_W'(DET_LAT))) ||
                    (state == S_DRAIN);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cyc       <= '0;
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else if (scanning && abort) begin
      state     <= S_IDLE;
      cyc       <= '0;
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            cyc       <= '0;
            match_cnt <= '0;
            first_idx <= '0;
            found     <= 1'b0;
            state     <= S_CLR;
          end
        end
        S_CLR: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg <= shreg >> 1;
          cyc   <= cyc + CYC_W'(1);
          if (cyc == CYC_W'(WIDTH - 1)) begin
            state <= (DET_LAT == 0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          cyc <= cyc + CYC_W'(1);
          if (cyc == CYC_W'(SCAN_LEN - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (samp && sd_o) begin
        if (match_cnt != CNT_W'(WIDTH)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
        if (!found) begin
          first_idx <= CNT_W'(k_idx);
          found     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Bench for sd_stream_ctrl: a registered (DET_LAT=1) and a combinational (DET_LAT=0)
// instance share stimulus; each drives its own overlapping "1011" detector model.
// Expected results come from scanning the word directly for the pattern.
module tb_sd_stream_ctrl;

  localparam int WIDTH = 10;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             abort = 1'b0;

  logic             in_ready_1, sd_rst_1, sd_i_1, sd_o_1, done_1, found_1;
  logic [CW-1:0]    match_cnt_1, first_idx_1;
  logic             in_ready_0, sd_rst_0, sd_i_0, sd_o_0, done_0, found_0;
  logic [CW-1:0]    match_cnt_0, first_idx_0;

  int checks = 0;
  int errors = 0;
  int acc1 = 0;
  int acc0 = 0;

  logic [3:0] hist1 = '0;
  logic [3:0] hist0 = '0;

  always #5 clk = ~clk;

  sd_stream_ctrl #(.WIDTH(WIDTH), .DET_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_data(in_data), .abort(abort), .sd_rst(sd_rst_1), .sd_i(sd_i_1),
    .sd_o(sd_o_1), .done(done_1), .match_cnt(match_cnt_1),
    .first_idx(first_idx_1), .found(found_1)
  );

  sd_stream_ctrl #(.WIDTH(WIDTH), .DET_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0),
    .in_data(in_data), .abort(abort), .sd_rst(sd_rst_0), .sd_i(sd_i_0),
    .sd_o(sd_o_0), .done(done_0), .match_cnt(match_cnt_0),
    .first_idx(first_idx_0), .found(found_0)
  );

  // Detector models: history of received bits, oldest in bit 3.
  always @(posedge clk) begin
    hist1 <= sd_rst_1 ? 4'b0000 : {hist1[2:0], sd_i_1};
    hist0 <= sd_rst_0 ? 4'b0000 : {hist0[2:0], sd_i_0};
    if (in_valid && in_ready_1) acc1 <= acc1 + 1;
    if (in_valid && in_ready_0) acc0 <= acc0 + 1;
  end
  assign sd_o_1 = (hist1 == 4'b1011);
  assign sd_o_0 = ({hist0[2:0], sd_i_0} == 4'b1011);

  function automatic void model(input logic [WIDTH-1:0] w, output logic [CW-1:0] cnt,
                                output logic [CW-1:0] first, output logic fnd);
    int c = 0;
    int f = 0;
    bit h = 0;
    for (int k = 3; k < WIDTH; k++) begin
      if (w[k-3] && !w[k-2] && w[k-1] && w[k]) begin
        c++;
        if (!h) begin
          f = k;
          h = 1;
        end
      end
    end
    cnt   = CW'(c);
    first = CW'(f);
    fnd   = h;
  endfunction

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 10'b1011011011;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready_1 !== 1'b0 || in_ready_0 !== 1'b0 || sd_rst_1 !== 1'b1 || sd_rst_0 !== 1'b1) begin
        errors++;
        $display("FAIL reset_ctrl cyc%0d: ready=%b/%b sd_rst=%b/%b, want ready=0 sd_rst=1",
                 c, in_ready_1, in_ready_0, sd_rst_1, sd_rst_0);
      end
      checks++;
      if ({done_1, done_0, found_1, found_0, sd_i_1, sd_i_0} !== 6'b0 ||
          {match_cnt_1, first_idx_1, match_cnt_0, first_idx_0} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outs cyc%0d: done=%b/%b found=%b/%b sd_i=%b/%b cnt=%0d/%0d idx=%0d/%0d, want all 0",
                 c, done_1, done_0, found_1, found_0, sd_i_1, sd_i_0,
                 match_cnt_1, match_cnt_0, first_idx_1, first_idx_0);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready_1 !== 1'b1 || in_ready_0 !== 1'b1 || sd_rst_1 !== 1'b0 || sd_rst_0 !== 1'b0 ||
        acc1 != 0 || acc0 != 0) begin
      errors++;
      $display("FAIL reset_release: ready=%b/%b sd_rst=%b/%b accepts=%0d/%0d, want ready=1 sd_rst=0 accepts=0",
               in_ready_1, in_ready_0, sd_rst_1, sd_rst_0, acc1, acc0);
    end
  endtask

  // Starts and ends at a negedge in the first IDLE cycle of the DET_LAT=1 instance.
  task automatic run_scan(input logic [WIDTH-1:0] word, input bit hold_valid, input string name);
    logic [CW-1:0]    ec, ef;
    logic             efd;
    logic [WIDTH-1:0] bits1, bits0;
    int d1_n = 0, d1_e = -1, d0_n = 0, d0_e = -1;
    int busy_bad = 0, stray = 0;
    int a1, a0;
    model(word, ec, ef, efd);
    bits1 = '0;
    bits0 = '0;
    checks++;
    if (in_ready_1 !== 1'b1 || in_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_pre: ready=%b/%b, want 1/1", name, in_ready_1, in_ready_0);
    end
    in_valid = 1'b1;
    in_data  = word;
    a1 = acc1;
    a0 = acc0;
    @(posedge clk);
    #1;
    in_data = WIDTH'($urandom);
    if (!hold_valid) in_valid = 1'b0;
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      if (e == 0) begin
        checks++;
        if (sd_rst_1 !== 1'b1 || sd_rst_0 !== 1'b1 ||
            {match_cnt_1, first_idx_1, match_cnt_0, first_idx_0} !== 16'h0 ||
            found_1 !== 1'b0 || found_0 !== 1'b0) begin
          errors++;
          $display("FAIL %s clr_cycle: sd_rst=%b/%b cnt=%0d/%0d idx=%0d/%0d found=%b/%b, want sd_rst=1 results 0",
                   name, sd_rst_1, sd_rst_0, match_cnt_1, match_cnt_0,
                   first_idx_1, first_idx_0, found_1, found_0);
        end
      end
      if (e >= 1 && e <= WIDTH) begin
        bits1[e-1] = sd_i_1;
        bits0[e-1] = sd_i_0;
      end else if (sd_i_1 !== 1'b0 || sd_i_0 !== 1'b0) begin
        stray++;
      end
      if (e <= 10 && (in_ready_1 !== 1'b0 || in_ready_0 !== 1'b0)) busy_bad++;
      if (done_1 === 1'b1) begin d1_n++; if (d1_e < 0) d1_e = e; end
      if (done_0 === 1'b1) begin d0_n++; if (d0_e < 0) d0_e = e; end
      if (e == 11) begin
        checks++;
        if (match_cnt_0 !== ec || first_idx_0 !== ef || found_0 !== efd) begin
          errors++;
          $display("FAIL %s result_lat0: cnt=%0d idx=%0d found=%b, want cnt=%0d idx=%0d found=%b",
                   name, match_cnt_0, first_idx_0, found_0, ec, ef, efd);
        end
      end
      if (e == 12) begin
        checks++;
        if (match_cnt_1 !== ec || first_idx_1 !== ef || found_1 !== efd) begin
          errors++;
          $display("FAIL %s result_lat1: cnt=%0d idx=%0d found=%b, want cnt=%0d idx=%0d found=%b",
                   name, match_cnt_1, first_idx_1, found_1, ec, ef, efd);
        end
        in_valid = 1'b0;
      end
    end
    checks++;
    if (bits1 !== word || bits0 !== word || stray != 0) begin
      errors++;
      $display("FAIL %s sd_i_seq: got %b/%b stray=%0d, want %b stray=0", name, bits1, bits0, stray, word);
    end
    checks++;
    if (d1_n != 1 || d1_e != 12 || d0_n != 1 || d0_e != 11) begin
      errors++;
      $display("FAIL %s done_timing: lat1 %0d pulses at edge %0d, lat0 %0d pulses at edge %0d, want 1@12 and 1@11",
               name, d1_n, d1_e, d0_n, d0_e);
    end
    checks++;
    if (busy_bad != 0 || acc1 - a1 != 1 || acc0 - a0 != 1 || in_ready_1 !== 1'b1 || in_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: busy_ready=%0d accepts=%0d/%0d ready_end=%b/%b, want 0, 1/1, 1/1",
               name, busy_bad, acc1 - a1, acc0 - a0, in_ready_1, in_ready_0);
    end
    checks++;
    if (match_cnt_1 !== ec || first_idx_1 !== ef || found_1 !== efd ||
        match_cnt_0 !== ec || first_idx_0 !== ef || found_0 !== efd) begin
      errors++;
      $display("FAIL %s result_hold: cnt=%0d/%0d idx=%0d/%0d found=%b/%b, want cnt=%0d idx=%0d found=%b",
               name, match_cnt_1, match_cnt_0, first_idx_1, first_idx_0, found_1, found_0, ec, ef, efd);
    end
  endtask

  // Cancels a scan either by abort or by rst at a given shift cycle.
  task automatic test_cancel(input bit use_rst, input int at_k, input string name);
    int dn = 0;
    in_valid = 1'b1;
    in_data  = 10'b0000001101;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int e = 0; e <= at_k + 1; e++) @(negedge clk);
    if (!use_rst) begin
      checks++;
      if (match_cnt_1 !== 4'd1 || match_cnt_0 !== 4'd1) begin
        errors++;
        $display("FAIL %s pre_cancel_cnt: cnt=%0d/%0d, want 1/1", name, match_cnt_1, match_cnt_0);
      end
    end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(negedge clk);
    if (use_rst) begin
      checks++;
      if (sd_rst_1 !== 1'b1 || sd_rst_0 !== 1'b1 || in_ready_1 !== 1'b0 || in_ready_0 !== 1'b0) begin
        errors++;
        $display("FAIL %s rst_cycle: sd_rst=%b/%b ready=%b/%b, want 1/1 and 0/0",
                 name, sd_rst_1, sd_rst_0, in_ready_1, in_ready_0);
      end
      rst = 1'b0;
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (in_ready_1 !== 1'b1 || in_ready_0 !== 1'b1 || done_1 !== 1'b0 || done_0 !== 1'b0 ||
        {match_cnt_1, first_idx_1, match_cnt_0, first_idx_0} !== 16'h0 ||
        found_1 !== 1'b0 || found_0 !== 1'b0 || sd_rst_1 !== 1'b0) begin
      errors++;
      $display("FAIL %s post_cancel: ready=%b/%b done=%b/%b cnt=%0d/%0d idx=%0d/%0d found=%b/%b sd_rst=%b, want idle zeros",
               name, in_ready_1, in_ready_0, done_1, done_0, match_cnt_1, match_cnt_0,
               first_idx_1, first_idx_0, found_1, found_0, sd_rst_1);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_1 === 1'b1 || done_0 === 1'b1 || in_ready_1 !== 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL %s no_done_after_cancel: %0d bad cycles, want 0", name, dn);
    end
  endtask

  task automatic test_back_to_back();
    run_scan(10'b0000000000, 1'b0, "zero_word");
    run_scan(10'b1011011011, 1'b1, "b2b_hold_valid");
    run_scan(10'b0001101011, 1'b0, "b2b_clears");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] w;
      bit hv;
      w  = WIDTH'($urandom);
      hv = 1'($urandom_range(0, 1));
      run_scan(w, hv, "random");
    end
  endtask

  initial begin
    test_reset();
    run_scan(10'b0001101011, 1'b0, "single_match");
    run_scan(10'b1011011011, 1'b0, "overlap");
    test_back_to_back();
    test_cancel(1'b0, 5, "abort_k5");
    test_cancel(1'b1, 3, "rst_k3");
    run_scan(10'b1111111111, 1'b0, "all_ones");
    run_scan(10'b1101101101, 1'b0, "dense");
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
Sequencing controller for the serial sequence detector (ports i, clk, o). It accepts a parallel word over a valid/ready handshake, clears the detector, and shifts the word into the detector LSB-first at one bit per clock. It samples the detector output with a fixed latency and reports the match count and the first match position. It sits between a parallel producer and the detector, replacing bench-style free-running bit feeding.

Parameters:
WIDTH, 10, bits per word shifted into the detector
DET_LAT, 1, clocks from sd_i carrying bit k to sd_o reflecting bit k (0 allowed = combinational Mealy output)
CNT_W, $clog2(WIDTH+1), derived local width of the count/index outputs; not overridable

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  producer has word on in_data
in_ready  out  1  block can accept a word
in_data  in  WIDTH  word to scan, bit 0 sent first
abort  in  1  cancel current scan
sd_rst  out  1  clear pulse to detector
sd_i  out  1  serial bit to detector input i
sd_o  in  1  detector output o
done  out  1  one-cycle pulse, results valid
match_cnt  out  CNT_W  number of sampled sd_o highs in the scan
first_idx  out  CNT_W  bit index k of first match, 0 if none
found  out  1  at least one match in last scan

Behaviour:
- Single clock. rst is sampled only at clk edges and overrides everything: state=IDLE, done=0, match_cnt=0, first_idx=0, found=0, shift register=0, sd_i=0.
- in_ready = (state==IDLE) && !rst. sd_rst = rst || (state==CLR). sd_i = 0 outside SHIFT.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: on in_valid && in_ready at edge t0: latch in_data, clear match_cnt/first_idx/found, bit counter=0, go to CLR.
- CLR: one cycle, sd_rst=1, then go to SHIFT.
- SHIFT: cycle k (k=0..WIDTH-1) drives sd_i = latched_data[k]. After k=WIDTH-1, go to DRAIN; if DET_LAT=0, go directly to DONE.
- DRAIN: DET_LAT cycles with sd_i=0, then go to DONE.
- Sampling: at the edge ending scan cycle k+DET_LAT (cycles counted from the first SHIFT cycle, continuing into DRAIN), sd_o is attributed to bit k, for k=0..WIDTH-1. sd_o outside these windows, including CLR, is ignored.
- On each attributed high: match_cnt += 1 (cannot exceed WIDTH, no wrap). If found==0, set first_idx=k and found=1.
- DONE: done=1 for exactly one cycle, then go to IDLE. done is first high in the cycle after edge t0+WIDTH+DET_LAT+1 (edge 12 for defaults).
- match_cnt, first_idx and found hold their values from the DONE cycle until the next accepting edge.
- abort: sampled at any edge in CLR, SHIFT or DRAIN. The block goes to IDLE next cycle, no done pulse, match_cnt=0, first_idx=0, found=0. abort has no effect in IDLE or DONE.
- in_valid while not IDLE is ignored; no word is lost because in_ready=0.
- Back-to-back operation: a word may be accepted at the edge that ends the cycle after DONE (first IDLE cycle).
- rst asserted mid-scan behaves like abort, plus sd_rst=1 for the reset cycles.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, sd_rst=1, all outputs 0, no accept. After release: in_ready=1, sd_rst=0.
2. Detector model "1011" overlapping, DET_LAT=1, in_data=10'b0001101011 -> sd_rst high 1 cycle, then sd_i=1,1,0,1,0,1,1,0,0,0. done at edge 12 after accept; match_cnt=1, first_idx=6, found=1.
3. Same model, in_data=10'b1011011011 -> sd_i=1,1,0,1,1,0,1,1,0,1. Overlapping detection gives match_cnt=2, first_idx=4, found=1.
4. in_data=0 -> match_cnt=0, first_idx=0, found=0, done still at edge 12. Then a second word is accepted in the first IDLE cycle after done, and the previous results clear at that accepting edge.
5. in_valid held high during the scan -> exactly one accept per scan. abort at SHIFT cycle 5 -> IDLE next cycle, no done, all results 0, in_ready=1.
6. DET_LAT=0 with a combinational model, word from scenario 2 -> no DRAIN state, done at edge 11, match_cnt=1, first_idx=6. rst pulsed at SHIFT cycle 3 -> IDLE, no done.
